// File: rtl/fxp_op_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : fxp_pkg
// Brief  : Shared types and helpers for the fixed-point operation scheduler.
// Rev    : 1.0
// ============================================================================
package fxp_pkg;

  typedef enum logic [1:0] {
    FXP_ADD     = 2'b00,
    FXP_SUB     = 2'b01,
    FXP_MUL     = 2'b10,
    FXP_ILLEGAL = 2'b11
  } fxp_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } fxp_sched_state_t;

  localparam int C_MAX_LATENCY = 15;
  localparam int C_CNT_W       = 4;

  function automatic int fxp_word_width(input int whole_w, input int frac_w);
    return whole_w + frac_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_op_scheduler_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fxp_rr_arbiter
// Brief  : Combinational round-robin grant; search starts at i_ptr and wraps.
// Rev    : 1.0
// ============================================================================
module fxp_rr_arbiter
  import fxp_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx
);

  int   w_cand;
  logic w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = (int'(i_ptr) + k) % NUM_REQ;
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_grant[w_cand]  = 1'b1;
        o_idx            = w_cand[ID_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fxp_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module : fxp_op_scheduler
// Brief  : Round-robin sequencer for a shared fixed-point add/sub/mul datapath.
// Rev    : 1.0
// ============================================================================
module fxp_op_scheduler
  import fxp_pkg::*;
#(
  parameter int wholeWidth    = 16,
  parameter int fractionWidth = 16,
  parameter int NUM_REQ       = 2,
  parameter int OP_LATENCY    = 1,
  localparam int W            = fxp_word_width(wholeWidth, fractionWidth),
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [2*NUM_REQ-1:0] req_op,
  input  logic [W*NUM_REQ-1:0] req_a,
  input  logic [W*NUM_REQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [W-1:0]         rsp_data,
  output logic                 rsp_err,
  output logic                 calculate_en,
  output logic [W-1:0]         valueOne,
  output logic [W-1:0]         valueTwo,
  input  logic [W-1:0]         addend,
  input  logic [W-1:0]         difference,
  input  logic [W-1:0]         product
);

  if (OP_LATENCY < 1 || OP_LATENCY > C_MAX_LATENCY) begin : g_bad_latency
    $error("fxp_op_scheduler: OP_LATENCY must be within 1..15");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fxp_op_scheduler: NUM_REQ must be within 2..8");
  end

  fxp_sched_state_t     r_state;
  fxp_op_t              r_op;
  logic [ID_W-1:0]      r_ptr;
  logic [ID_W-1:0]      r_id;
  logic [C_CNT_W-1:0]   r_cnt;
  logic                 r_calc_en;
  logic [W-1:0]         r_value_one;
  logic [W-1:0]         r_value_two;
  logic                 r_rsp_valid;
  logic [ID_W-1:0]      r_rsp_id;
  logic [W-1:0]         r_rsp_data;
  logic                 r_rsp_err;

  logic [NUM_REQ-1:0]   w_grant;
  logic [ID_W-1:0]      w_idx;
  logic [NUM_REQ-1:0]   w_req_ready;
  logic                 w_accept;
  logic [ID_W-1:0]      w_ptr_next;

  fxp_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // The grant is only offered while idle; reset masks it so every output is 0.
  assign w_req_ready = (r_state == IDLE && !reset) ? w_grant : '0;
  assign w_accept    = |(req_valid & w_req_ready);
  assign w_ptr_next  = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + ID_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_op        <= FXP_ADD;
      r_ptr       <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_calc_en   <= 1'b0;
      r_value_one <= '0;
      r_value_two <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op        <= fxp_op_t'(req_op[2*int'(w_idx) +: 2]);
            r_id        <= w_idx;
            r_ptr       <= w_ptr_next;
            r_value_one <= req_a[W*int'(w_idx) +: W];
            r_value_two <= req_b[W*int'(w_idx) +: W];
            r_calc_en   <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_calc_en <= 1'b0;
          r_cnt     <= C_CNT_W'(OP_LATENCY - 1);
          r_state   <= WAIT;
        end
        WAIT: begin
          if (r_cnt == '0) begin
            case (r_op)
              FXP_ADD:     r_rsp_data <= addend;
              FXP_SUB:     r_rsp_data <= difference;
              FXP_MUL:     r_rsp_data <= product;
              FXP_ILLEGAL: r_rsp_data <= '0;
              default:     r_rsp_data <= '0;
            endcase
            r_rsp_err   <= (r_op == FXP_ILLEGAL);
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - C_CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready    = w_req_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_data     = r_rsp_data;
  assign rsp_err      = r_rsp_err;
  assign calculate_en = r_calc_en;
  assign valueOne     = r_value_one;
  assign valueTwo     = r_value_two;

endmodule
`default_nettype wire

// File: tb/tb_fxp_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_fxp_op_scheduler
// Brief  : Directed self-checking bench for fxp_op_scheduler (latency 1 and 4).
// Rev    : 1.0
// ============================================================================
module tb_fxp_op_scheduler;

  localparam logic [31:0] C_A = 32'h0001_8000;
  localparam logic [31:0] C_B = 32'h0002_4000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  int          checks = 0;
  int          failures = 0;

  logic [1:0]  req_valid = '0, req_ready;
  logic [3:0]  req_op = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, calculate_en;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_data, valueOne, valueTwo, addend, difference, product;

  logic [1:0]  req_valid4 = '0, req_ready4;
  logic [3:0]  req_op4 = '0;
  logic [63:0] req_a4 = '0, req_b4 = '0;
  logic        rsp_valid4, rsp_ready4 = 1'b0, rsp_err4, cen4;
  logic [0:0]  rsp_id4;
  logic [31:0] rsp_data4, v1_4, v2_4, add4, diff4, prod4;

  int age = 0;
  int age4 = 0;

  always #5 clock = ~clock;

  fxp_op_scheduler #(.wholeWidth(16), .fractionWidth(16), .NUM_REQ(2), .OP_LATENCY(1)) u_dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .calculate_en(calculate_en), .valueOne(valueOne), .valueTwo(valueTwo),
    .addend(addend), .difference(difference), .product(product)
  );

  fxp_op_scheduler #(.wholeWidth(16), .fractionWidth(16), .NUM_REQ(2), .OP_LATENCY(4)) u_dut4 (
    .clock(clock), .reset(reset), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_op(req_op4), .req_a(req_a4), .req_b(req_b4), .rsp_valid(rsp_valid4),
    .rsp_ready(rsp_ready4), .rsp_id(rsp_id4), .rsp_data(rsp_data4), .rsp_err(rsp_err4),
    .calculate_en(cen4), .valueOne(v1_4), .valueTwo(v2_4),
    .addend(add4), .difference(diff4), .product(prod4)
  );

  function automatic logic [31:0] fx_mul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed(a) * $signed(b);
    return p[47:16];
  endfunction

  // Datapath model: results read as garbage until OP_LATENCY cycles after calculate_en.
  always @(posedge clock) begin
    if (calculate_en) age <= 1; else if (age < 50) age <= age + 1;
    if (cen4) age4 <= 1; else if (age4 < 50) age4 <= age4 + 1;
  end
  assign addend     = (age >= 1) ? valueOne + valueTwo : 32'hDEAD_BEEF;
  assign difference = (age >= 1) ? valueOne - valueTwo : 32'hDEAD_BEEF;
  assign product    = (age >= 1) ? fx_mul(valueOne, valueTwo) : 32'hDEAD_BEEF;
  assign add4       = (age4 >= 4) ? v1_4 + v2_4 : 32'hDEAD_BEEF;
  assign diff4      = (age4 >= 4) ? v1_4 - v2_4 : 32'hDEAD_BEEF;
  assign prod4      = (age4 >= 4) ? fx_mul(v1_4, v2_4) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("onehot0_ready", 64'($onehot0(req_ready)), 64'd1);
    end
  end

  task automatic op_check(input string tag, input int r, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_d, input logic exp_e);
    logic [1:0] oh;
    int lat;
    int cen_extra;
    oh = '0;
    oh[r] = 1'b1;
    req_valid[r] = 1'b1;
    req_op[2*r +: 2] = op;
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
    rsp_ready = 1'b1;
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(oh));
    step();
    req_valid[r] = 1'b0;
    chk({tag, "_cen"}, 64'(calculate_en), 64'd1);
    chk({tag, "_v1"}, 64'(valueOne), 64'(a));
    chk({tag, "_v2"}, 64'(valueTwo), 64'(b));
    lat = 1;
    cen_extra = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
      if (calculate_en) cen_extra++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd3);
    chk({tag, "_cen_once"}, 64'(cen_extra), 64'd0);
    chk({tag, "_data"}, 64'(rsp_data), 64'(exp_d));
    chk({tag, "_id"}, 64'(rsp_id), 64'(r));
    chk({tag, "_err"}, 64'(rsp_err), 64'(exp_e));
    step();
    chk({tag, "_valid_drop"}, 64'(rsp_valid), 64'd0);
  endtask

  task automatic op4_check(input string tag, input int r, input logic [1:0] op,
                           input logic [31:0] exp_d, input logic exp_e);
    logic [1:0] oh;
    int lat;
    oh = '0;
    oh[r] = 1'b1;
    req_valid4[r] = 1'b1;
    req_op4[2*r +: 2] = op;
    req_a4[32*r +: 32] = C_A;
    req_b4[32*r +: 32] = C_B;
    rsp_ready4 = 1'b1;
    #1;
    chk({tag, "_ready"}, 64'(req_ready4), 64'(oh));
    step();
    req_valid4[r] = 1'b0;
    chk({tag, "_cen"}, 64'(cen4), 64'd1);
    lat = 1;
    while (!rsp_valid4 && lat < 30) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd6);
    chk({tag, "_data"}, 64'(rsp_data4), 64'(exp_d));
    chk({tag, "_id"}, 64'(rsp_id4), 64'(r));
    chk({tag, "_err"}, 64'(rsp_err4), 64'(exp_e));
    step();
    chk({tag, "_valid_drop"}, 64'(rsp_valid4), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] exp_g;
    reset = 1'b1;
    step();
    step();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_cen", 64'(calculate_en), 64'd0);
    chk("rst_value_one", 64'(valueOne), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    reset = 1'b0;
    step();

    op_check("add_r0", 0, 2'b00, C_A, C_B, 32'h0003_C000, 1'b0);
    op_check("sub_r1", 1, 2'b01, C_A, C_B, 32'hFFFF_4000, 1'b0);

    // Both requesters continuously valid: grants alternate starting at 0.
    req_op = 4'b0000;
    req_a = {C_A, C_A};
    req_b = {C_B, C_B};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin
        step();
        n++;
      end
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("fair_grant", 64'(req_ready), 64'(exp_g));
      if (k > 0) chk("fair_period_gap", 64'(n), 64'd3);
      step();
    end
    req_valid = 2'b00;
    repeat (5) step();

    op_check("mul_r0", 0, 2'b10, C_A, C_B, 32'h0003_6000, 1'b0);

    // Backpressure: response held while req1 waits behind it.
    req_valid[0] = 1'b1;
    req_op[1:0] = 2'b00;
    rsp_ready = 1'b0;
    #1;
    chk("stall_ready", 64'(req_ready), 64'd1);
    step();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1;
    req_op[3:2] = 2'b11;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("stall_latency", 64'(n), 64'd2);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_data", 64'(rsp_data), 64'h0003_C000);
      chk("stall_id", 64'(rsp_id), 64'd0);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("stall_handshake_drop", 64'(rsp_valid), 64'd0);
    op_check("illegal_r1", 1, 2'b11, C_A, C_B, 32'h0000_0000, 1'b1);

    op4_check("lat4_illegal_r1", 1, 2'b11, 32'h0000_0000, 1'b1);
    op4_check("lat4_mul_r0", 0, 2'b10, 32'h0003_6000, 1'b0);

    // Reset while the L=1 instance is in WAIT after granting req0.
    req_valid[0] = 1'b1;
    req_op[1:0] = 2'b00;
    #1;
    chk("abort_ready", 64'(req_ready), 64'd1);
    step();
    req_valid[0] = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_cen", 64'(calculate_en), 64'd0);
    chk("abort_v1", 64'(valueOne), 64'd0);
    chk("abort_v2", 64'(valueTwo), 64'd0);
    chk("abort_data", 64'(rsp_data), 64'd0);
    chk("abort_id", 64'(rsp_id), 64'd0);
    chk("abort_err", 64'(rsp_err), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
    end
    req_valid = 2'b11;
    #1;
    chk("abort_ptr_reset", 64'(req_ready), 64'd1);
    req_valid = 2'b00;
    op_check("post_rst_r1", 1, 2'b00, C_A, C_B, 32'h0003_C000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
